// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame state encoding and the oversampling floor
// assumed by the pin synchronizers.
package spi_pkg;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

    // System clock must run at least this many times faster than SCLK.
    localparam int SPI_MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/spi_target_sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit, with a
// parameterised reset value so idle-high pins start inactive.
module sync_bit #(
    parameter int   SyncStages = 2,
    parameter logic ResetVal   = 1'b0
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] stages;

    // NOTE: clocked state uses <= so every stage samples the pre-edge value of
    // its neighbour; blocking = here would collapse the chain into one flop.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stages <= {SyncStages{ResetVal}};
        end else begin
            stages <= {stages[SyncStages-2:0], d_i};
        end
    end

    assign q_o = stages[SyncStages-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled CS/SCLK/MOSI, MSB-first byte shifting, and
// single-entry TX holding / RX output registers with valid-ready handshakes.
module spi_target
    import spi_pkg::*;
#(
    parameter int                    data_width = 8,
    parameter int                    SyncStages = 2,
    parameter logic [data_width-1:0] IdleByte   = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  cs_ni,
    input  logic                  sclk_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [data_width-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [data_width-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  overrun_o,
    output logic                  underrun_o,
    output logic                  busy_o
);

    localparam int CntW = (data_width > 2) ? $clog2(data_width) : 1;

    logic cs_sync, sclk_sync, mosi_sync;
    logic cs_q, sclk_q;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;

    spi_state_t            state;
    logic [CntW-1:0]       bit_cnt;
    logic [data_width-1:0] rx_shift, tx_shift, tx_hold;
    logic                  tx_full, load_pending;
    logic                  load_now, accept;
    logic [data_width-1:0] load_byte, rx_next;

    sync_bit #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_cs (
        .clk_i(clk_i), .reset_ni(reset_ni), .d_i(cs_ni), .q_o(cs_sync)
    );
    sync_bit #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sclk (
        .clk_i(clk_i), .reset_ni(reset_ni), .d_i(sclk_i), .q_o(sclk_sync)
    );
    sync_bit #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .reset_ni(reset_ni), .d_i(mosi_i), .q_o(mosi_sync)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b0;
        end else begin
            cs_q   <= cs_sync;
            sclk_q <= sclk_sync;
        end
    end

    assign cs_fall   =  cs_q   & ~cs_sync;
    assign cs_rise   = ~cs_q   &  cs_sync;
    assign sclk_rise = ~sclk_q &  sclk_sync;
    assign sclk_fall =  sclk_q & ~sclk_sync;

    // NOTE: every output of this block gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        load_now  = 1'b0;
        if (state == SPI_IDLE) begin
            load_now = cs_fall;
        end else begin
            load_now = ~cs_rise & sclk_fall & load_pending;
        end
        load_byte = tx_full ? tx_hold : IdleByte;
        accept    = tx_valid_i & ~tx_full;
        rx_next   = {rx_shift[data_width-2:0], mosi_sync};
    end

    // A load in the same cycle as an accept sees the holding register empty,
    // so the accepted byte waits for the next byte slot.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_full <= 1'b0;
            tx_hold <= '0;
        end else if (load_now && tx_full) begin
            tx_full <= 1'b0;
        end else if (accept) begin
            tx_full <= 1'b1;
            tx_hold <= tx_data_i;
        end
    end

    assign tx_ready_o = ~tx_full;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= SPI_IDLE;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            load_pending <= 1'b0;
            miso_o       <= 1'b0;
            miso_oe_o    <= 1'b0;
            busy_o       <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            overrun_o    <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            overrun_o  <= 1'b0;
            underrun_o <= 1'b0;
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            case (state)
                SPI_IDLE: begin
                    if (cs_fall) begin
                        state        <= SPI_ACTIVE;
                        bit_cnt      <= '0;
                        rx_shift     <= '0;
                        load_pending <= 1'b0;
                        tx_shift     <= load_byte;
                        miso_o       <= load_byte[data_width-1];
                        underrun_o   <= ~tx_full;
                        miso_oe_o    <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end

                SPI_ACTIVE: begin
                    if (cs_rise) begin
                        // Partial byte and any loaded TX byte are dropped.
                        state        <= SPI_IDLE;
                        bit_cnt      <= '0;
                        rx_shift     <= '0;
                        load_pending <= 1'b0;
                        miso_o       <= 1'b0;
                        miso_oe_o    <= 1'b0;
                        busy_o       <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == CntW'(data_width - 1)) begin
                                bit_cnt      <= '0;
                                rx_data_o    <= rx_next;
                                rx_valid_o   <= 1'b1;
                                overrun_o    <= rx_valid_o & ~rx_ready_i;
                                load_pending <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CntW'(1);
                            end
                        end
                        if (sclk_fall) begin
                            if (load_pending) begin
                                load_pending <= 1'b0;
                                tx_shift     <= load_byte;
                                miso_o       <= load_byte[data_width-1];
                                underrun_o   <= ~tx_full;
                            end else begin
                                tx_shift <= {tx_shift[data_width-2:0], 1'b0};
                                miso_o   <= tx_shift[data_width-2];
                            end
                        end
                    end
                end

                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: an SCLK = clk/8 master plus a byte-level model of
// what the target must shift out, receive, and flag.
module tb_spi_target;

    logic       clk_i = 1'b0;
    logic       reset_ni, cs_ni, sclk_i, mosi_i;
    logic       miso_o, miso_oe_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i, tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, rx_ready_i;
    logic       overrun_o, underrun_o, busy_o;

    spi_target #(.data_width(8), .SyncStages(2), .IdleByte(8'hFF)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .cs_ni(cs_ni), .sclk_i(sclk_i),
        .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .overrun_o(overrun_o), .underrun_o(underrun_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: bytes offered to the TX port in order, bytes the RX port
    // still owes the consumer, and the expected pulse totals.
    logic [7:0] drv_q[$];
    logic [7:0] model_tx[$];
    logic [7:0] rx_exp[$];
    logic [7:0] got[$];
    int und_exp = 0, ovr_exp = 0;

    // Observed event counts.
    int und_cnt = 0, ovr_cnt = 0, rxv_rise = 0, txr_rise = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // TX port driver: presents queued bytes, pops on handshake.
    initial begin
        bit hs;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        forever begin
            @(negedge clk_i);
            if (drv_q.size() > 0) begin
                tx_valid_i = 1'b1;
                tx_data_i  = drv_q[0];
            end else begin
                tx_valid_i = 1'b0;
            end
            hs = reset_ni && tx_valid_i && tx_ready_o;
            @(posedge clk_i);
            if (hs && drv_q.size() > 0) void'(drv_q.pop_front());
        end
    end

    // Per-cycle compare process.
    initial begin
        logic cs_prev = 1'b1;
        int   cs_run  = 0;
        logic rxv_prev = 1'b0, txr_prev = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                cs_run   = 0;
                cs_prev  = cs_ni;
                rxv_prev = 1'b0;
                txr_prev = 1'b1;
                continue;
            end
            if (cs_ni == cs_prev) cs_run++;
            else cs_run = 0;
            cs_prev = cs_ni;
            if (cs_run >= 4) begin
                check("busy_settled", {31'b0, busy_o}, {31'b0, ~cs_ni});
                check("miso_oe_settled", {31'b0, miso_oe_o}, {31'b0, ~cs_ni});
            end
            if (underrun_o) und_cnt++;
            if (overrun_o) ovr_cnt++;
            if (rx_valid_o && !rxv_prev) rxv_rise++;
            if (tx_ready_o && !txr_prev) txr_rise++;
            rxv_prev = rx_valid_o;
            txr_prev = tx_ready_o;
            if (rx_valid_o && rx_ready_i) begin
                if (rx_exp.size() == 0) begin
                    n_checks++;
                    $display("FAIL rx_spurious: got 0x%0h, expected no byte at %0t", rx_data_o, $time);
                end else begin
                    check("rx_consume", {24'b0, rx_data_o}, {24'b0, rx_exp.pop_front()});
                end
            end
        end
    end

    task automatic xfer_byte(input logic [7:0] b, input int nbits, input bit last,
                             output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi_i = b[7-i];
            tick(4);
            r = {r[6:0], miso_o};
            sclk_i = 1'b1;
            tick(4);
            sclk_i = 1'b0;
            if (last && i == nbits - 1) cs_ni = 1'b1;
        end
    endtask

    // One CS-low frame of n full bytes plus an optional partial byte of tail bits.
    task automatic run_frame(input logic [7:0] bytes [0:2], input int n, input int tail);
        int         slots;
        logic [7:0] exp_tx [0:3];
        logic [7:0] r;
        slots = n + ((tail > 0) ? 1 : 0);
        for (int k = 0; k < slots; k++) begin
            if (model_tx.size() > 0) exp_tx[k] = model_tx.pop_front();
            else begin
                exp_tx[k] = 8'hFF;
                und_exp++;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (!rx_ready_i && rx_exp.size() > 0) begin
                rx_exp[rx_exp.size()-1] = bytes[k];
                ovr_exp++;
            end else begin
                rx_exp.push_back(bytes[k]);
            end
        end
        got.delete();
        cs_ni = 1'b0;
        tick(8);
        for (int k = 0; k < slots; k++) begin
            xfer_byte(bytes[k], (k < n) ? 8 : tail, k == slots - 1, r);
            if (k < n) begin
                got.push_back(r);
                check("miso_byte", {24'b0, r}, {24'b0, exp_tx[k]});
            end
        end
        tick(8);
    endtask

    task automatic offer(input logic [7:0] b);
        drv_q.push_back(b);
        model_tx.push_back(b);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int u0, r0, t0, o0, n, tail, k;
        logic [7:0] bytes [0:2];

        reset_ni = 1'b0; cs_ni = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; rx_ready_i = 1'b1;
        #1;
        check("rst_miso", {31'b0, miso_o}, 32'd0);
        check("rst_miso_oe", {31'b0, miso_oe_o}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready_o}, 32'd1);
        check("rst_rx_valid", {31'b0, rx_valid_o}, 32'd0);
        check("rst_rx_data", {24'b0, rx_data_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        tick(4);
        reset_ni = 1'b1;
        tick(8);

        // Preloaded byte goes out, one byte in.
        offer(8'hA5);
        tick(4);
        u0 = und_cnt; r0 = rxv_rise;
        run_frame('{8'h3C, 8'h00, 8'h00}, 1, 0);
        check("t1_master_rx", {24'b0, got[0]}, 32'hA5);
        check("t1_rx_data", {24'b0, rx_data_o}, 32'h3C);
        check("t1_rx_valid_once", rxv_rise - r0, 32'd1);
        check("t1_no_underrun", und_cnt - u0, 32'd0);

        // Empty TX: idle bytes and one underrun per byte slot.
        u0 = und_cnt; r0 = rxv_rise;
        run_frame('{8'h01, 8'h02, 8'h00}, 2, 0);
        check("t2_master_rx0", {24'b0, got[0]}, 32'hFF);
        check("t2_master_rx1", {24'b0, got[1]}, 32'hFF);
        check("t2_underruns", und_cnt - u0, 32'd2);
        check("t2_rx_valids", rxv_rise - r0, 32'd2);

        // Consumer stalled: later bytes overwrite.
        rx_ready_i = 1'b0;
        u0 = und_cnt; o0 = ovr_cnt;
        run_frame('{8'h11, 8'h22, 8'h33}, 3, 0);
        check("t3_overruns", ovr_cnt - o0, 32'd2);
        check("t3_underruns", und_cnt - u0, 32'd3);
        check("t3_rx_data", {24'b0, rx_data_o}, 32'h33);
        check("t3_rx_valid", {31'b0, rx_valid_o}, 32'd1);
        rx_ready_i = 1'b1;
        tick(4);
        check("t3_rx_drained", {31'b0, rx_valid_o}, 32'd0);

        // Streamed TX bytes, one per byte slot.
        offer(8'h10); offer(8'h20); offer(8'h30);
        tick(4);
        u0 = und_cnt; t0 = txr_rise;
        run_frame('{8'hC1, 8'hC2, 8'hC3}, 3, 0);
        check("t4_master_rx0", {24'b0, got[0]}, 32'h10);
        check("t4_master_rx1", {24'b0, got[1]}, 32'h20);
        check("t4_master_rx2", {24'b0, got[2]}, 32'h30);
        check("t4_tx_ready_rises", txr_rise - t0, 32'd3);
        check("t4_no_underrun", und_cnt - u0, 32'd0);

        // Aborted frame after 5 bits, then a clean byte.
        r0 = rxv_rise;
        run_frame('{8'hE7, 8'h00, 8'h00}, 0, 5);
        check("t5_no_partial_rx", rxv_rise - r0, 32'd0);
        run_frame('{8'h5A, 8'h00, 8'h00}, 1, 0);
        check("t5_rx_data", {24'b0, rx_data_o}, 32'h5A);
        check("t5_rx_valid_once", rxv_rise - r0, 32'd1);

        // Randomized frames against the model.
        for (int it = 0; it < 24; it++) begin
            n = $urandom_range(1, 3);
            tail = 0;
            if (n < 3 && ($urandom_range(0, 3) == 0)) tail = $urandom_range(1, 7);
            for (int b = 0; b < 3; b++) bytes[b] = 8'($urandom);
            k = $urandom_range(0, 3);
            for (int b = 0; b < k; b++) offer(8'($urandom));
            tick(4);
            run_frame(bytes, n, tail);
        end
        tick(4);
        check("rand_underruns", und_cnt, und_exp);
        check("rand_overruns", ovr_cnt, ovr_exp);
        check("rand_rx_all_consumed", rx_exp.size(), 32'd0);

        // Asynchronous reset mid-byte with the holding register full.
        offer(8'h66); offer(8'h77);
        tick(4);
        cs_ni = 1'b0;
        tick(8);
        begin
            logic [7:0] r;
            xfer_byte(8'hC3, 4, 1'b0, r);
        end
        @(posedge clk_i);
        #3;
        reset_ni = 1'b0;
        #1;
        check("mid_rst_miso", {31'b0, miso_o}, 32'd0);
        check("mid_rst_miso_oe", {31'b0, miso_oe_o}, 32'd0);
        check("mid_rst_tx_ready", {31'b0, tx_ready_o}, 32'd1);
        check("mid_rst_rx_data", {24'b0, rx_data_o}, 32'd0);
        check("mid_rst_rx_valid", {31'b0, rx_valid_o}, 32'd0);
        check("mid_rst_overrun", {31'b0, overrun_o}, 32'd0);
        check("mid_rst_underrun", {31'b0, underrun_o}, 32'd0);
        check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        cs_ni = 1'b1;
        drv_q.delete();
        model_tx.delete();
        rx_exp.delete();
        tick(4);
        reset_ni = 1'b1;
        tick(8);
        u0 = und_cnt;
        run_frame('{8'h96, 8'h00, 8'h00}, 1, 0);
        check("t6_idle_after_reset", {24'b0, got[0]}, 32'hFF);
        check("t6_underrun", und_cnt - u0, 32'd1);
        check("t6_rx_data", {24'b0, rx_data_o}, 32'h96);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
